// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron gate learner.
package perceptron_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of input patterns in one epoch. idx = {x1, x2}.
  localparam int N_PATTERNS = 4;
  localparam int IDX_WIDTH  = 2;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int width);
    int hi;
    int lo;
    int sum;
    hi  = (1 << (width - 1)) - 1;
    lo  = -(1 << (width - 1));
    sum = a + b;
    if (sum > hi)      sat_add = hi;
    else if (sum < lo) sat_add = lo;
    else               sat_add = sum;
  endfunction

endpackage

// File: rtl/perceptron_neuron.sv
// Combinational 2-input neuron: y = (w1*x1 + w2*x2 + bias > 0).
module perceptron_neuron #(
  parameter int W_WIDTH = 4
) (
  input  logic signed [W_WIDTH-1:0] w1,
  input  logic signed [W_WIDTH-1:0] w2,
  input  logic signed [W_WIDTH-1:0] bias,
  input  logic                      x1,
  input  logic                      x2,
  output logic                      y
);

  // Two guard bits hold the sum of three W_WIDTH-bit terms without overflow.
  localparam int SW = W_WIDTH + 2;

  logic signed [SW-1:0] sum;

  // Weighted sum and threshold; a zero sum maps to 0.
  always_comb begin
    sum = SW'(bias);
    if (x1) sum = sum + SW'(w1);
    if (x2) sum = sum + SW'(w2);
    y = (sum > SW'(0));
  end

endmodule

// File: rtl/perceptron_gate_learner.sv
// Learns the weights of a 2-input perceptron that reproduces a given
// 4-entry truth table, one pattern per cycle, with a live inference output.
module perceptron_gate_learner
  import perceptron_pkg::*;
#(
  parameter int W_WIDTH    = 4,
  parameter int MAX_EPOCHS = 16,
  parameter int EP_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                target,
  input  logic                      e1,
  input  logic                      e2,
  output logic                      s,
  output logic signed [W_WIDTH-1:0] w1,
  output logic signed [W_WIDTH-1:0] w2,
  output logic signed [W_WIDTH-1:0] bias,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic [EP_WIDTH-1:0]       epochs
);

  state_e                      state_q, state_d;
  logic [3:0]                  target_q, target_d;
  logic signed [W_WIDTH-1:0]   w1_q, w1_d;
  logic signed [W_WIDTH-1:0]   w2_q, w2_d;
  logic signed [W_WIDTH-1:0]   bias_q, bias_d;
  logic [EP_WIDTH-1:0]         epochs_q, epochs_d;
  logic                        conv_q, conv_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic                        err_flag_q, err_flag_d;

  logic x1, x2;
  logic y_train;
  logic tgt_bit;
  logic err_nz;
  int   delta;

  // The pattern index doubles as the training inputs.
  assign x1      = idx_q[1];
  assign x2      = idx_q[0];
  assign tgt_bit = target_q[idx_q];
  assign err_nz  = tgt_bit ^ y_train;

  perceptron_neuron #(.W_WIDTH(W_WIDTH)) u_train_neuron (
    .w1   (w1_q),
    .w2   (w2_q),
    .bias (bias_q),
    .x1   (x1),
    .x2   (x2),
    .y    (y_train)
  );

  perceptron_neuron #(.W_WIDTH(W_WIDTH)) u_infer_neuron (
    .w1   (w1_q),
    .w2   (w2_q),
    .bias (bias_q),
    .x1   (e1),
    .x2   (e2),
    .y    (s)
  );

  // Next-state and training update logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    target_d   = target_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    bias_d     = bias_q;
    epochs_d   = epochs_q;
    conv_d     = conv_q;
    idx_d      = idx_q;
    err_flag_d = err_flag_q;
    // err is +1 when the target is 1 and y is 0, -1 in the opposite case.
    delta      = tgt_bit ? 1 : -1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d   = target;
          w1_d       = '0;
          w2_d       = '0;
          bias_d     = '0;
          epochs_d   = '0;
          conv_d     = 1'b0;
          idx_d      = '0;
          err_flag_d = 1'b0;
          state_d    = ST_TRAIN;
        end
      end

      ST_TRAIN: begin
        if (err_nz) begin
          if (x1) w1_d = W_WIDTH'(sat_add(int'(w1_q), delta, W_WIDTH));
          if (x2) w2_d = W_WIDTH'(sat_add(int'(w2_q), delta, W_WIDTH));
          bias_d     = W_WIDTH'(sat_add(int'(bias_q), delta, W_WIDTH));
          err_flag_d = 1'b1;
        end
        // Index wraps 3 -> 0 on its own.
        idx_d = idx_q + IDX_WIDTH'(1);
        if (idx_q == IDX_WIDTH'(N_PATTERNS - 1)) begin
          epochs_d = epochs_q + EP_WIDTH'(1);
          if (!err_flag_q && !err_nz) begin
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else if (epochs_q == EP_WIDTH'(MAX_EPOCHS - 1)) begin
            state_d = ST_DONE;
          end else begin
            err_flag_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      bias_q     <= '0;
      epochs_q   <= '0;
      conv_q     <= 1'b0;
      idx_q      <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      bias_q     <= bias_d;
      epochs_q   <= epochs_d;
      conv_q     <= conv_d;
      idx_q      <= idx_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign w1        = w1_q;
  assign w2        = w2_q;
  assign bias      = bias_q;
  assign busy      = (state_q == ST_TRAIN);
  assign done      = (state_q == ST_DONE);
  assign converged = conv_q;
  assign epochs    = epochs_q;

endmodule

// File: tb/tb_perceptron_gate_learner.sv
// Scoreboard bench for perceptron_gate_learner: three instances
// (default, MAX_EPOCHS=8, W_WIDTH=2); expected results are queued at start
// and compared by per-instance monitors whenever done pulses.
module tb_perceptron_gate_learner;

  typedef struct {
    int conv;
    int epochs;
    int w1;
    int w2;
    int bias;
    bit chk_w;
    int lat;
    int busy_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  // Instance a: defaults
  logic              a_start, a_e1, a_e2, a_s, a_busy, a_done, a_conv;
  logic [3:0]        a_target;
  logic signed [3:0] a_w1, a_w2, a_bias;
  logic [4:0]        a_epochs;
  // Instance x: MAX_EPOCHS = 8
  logic              x_start, x_e1, x_e2, x_s, x_busy, x_done, x_conv;
  logic [3:0]        x_target;
  logic signed [3:0] x_w1, x_w2, x_bias;
  logic [4:0]        x_epochs;
  // Instance c: W_WIDTH = 2 (clamping)
  logic              c_start, c_e1, c_e2, c_s, c_busy, c_done, c_conv;
  logic [3:0]        c_target;
  logic signed [1:0] c_w1, c_w2, c_bias;
  logic [4:0]        c_epochs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int a_t0 = 0, x_t0 = 0, c_t0 = 0;
  int a_bc = 0, x_bc = 0, c_bc = 0;
  exp_t q_a[$], q_x[$], q_c[$];
  exp_t ea, ex, ec;

  perceptron_gate_learner dut_a (
    .clk(clk), .rst(rst), .start(a_start), .target(a_target), .e1(a_e1), .e2(a_e2),
    .s(a_s), .w1(a_w1), .w2(a_w2), .bias(a_bias), .busy(a_busy), .done(a_done),
    .converged(a_conv), .epochs(a_epochs)
  );

  perceptron_gate_learner #(.W_WIDTH(4), .MAX_EPOCHS(8), .EP_WIDTH(5)) dut_x (
    .clk(clk), .rst(rst), .start(x_start), .target(x_target), .e1(x_e1), .e2(x_e2),
    .s(x_s), .w1(x_w1), .w2(x_w2), .bias(x_bias), .busy(x_busy), .done(x_done),
    .converged(x_conv), .epochs(x_epochs)
  );

  perceptron_gate_learner #(.W_WIDTH(2), .MAX_EPOCHS(16), .EP_WIDTH(5)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .target(c_target), .e1(c_e1), .e2(c_e2),
    .s(c_s), .w1(c_w1), .w2(c_w2), .bias(c_bias), .busy(c_busy), .done(c_done),
    .converged(c_conv), .epochs(c_epochs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t mk(input int conv, input int ep, input int w1, input int w2,
                              input int b, input bit chk_w, input int lat, input int bc);
    exp_t e;
    e.conv = conv; e.epochs = ep; e.w1 = w1; e.w2 = w2; e.bias = b;
    e.chk_w = chk_w; e.lat = lat; e.busy_cyc = bc;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic conv,
                         input logic signed [31:0] ep, input logic signed [31:0] w1,
                         input logic signed [31:0] w2, input logic signed [31:0] b,
                         input int lat, input int bc);
    check({tag, "_converged"}, conv, e.conv);
    check({tag, "_epochs"}, ep, e.epochs);
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_busy_cycles"}, bc, e.busy_cyc);
    if (e.chk_w) begin
      check({tag, "_w1"}, w1, e.w1);
      check({tag, "_w2"}, w2, e.w2);
      check({tag, "_bias"}, b, e.bias);
    end
  endtask

  // Track the accepted start edge and busy cycles per instance.
  always @(posedge clk) begin
    cyc++;
    if (!rst && a_start && !a_busy && !a_done) begin a_t0 = cyc; a_bc = 0; end
    if (!rst && x_start && !x_busy && !x_done) begin x_t0 = cyc; x_bc = 0; end
    if (!rst && c_start && !c_busy && !c_done) begin c_t0 = cyc; c_bc = 0; end
  end

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (a_busy) a_bc++;
    if (a_done) begin
      if (q_a.size() == 0) fail_now("a_unexpected_done");
      else begin
        ea = q_a.pop_front();
        compare("a", ea, a_conv, a_epochs, a_w1, a_w2, a_bias, cyc - a_t0 + 1, a_bc);
      end
    end
  end

  always @(negedge clk) begin
    if (x_busy) x_bc++;
    if (x_done) begin
      if (q_x.size() == 0) fail_now("x_unexpected_done");
      else begin
        ex = q_x.pop_front();
        compare("x", ex, x_conv, x_epochs, x_w1, x_w2, x_bias, cyc - x_t0 + 1, x_bc);
      end
    end
  end

  always @(negedge clk) begin
    if (c_busy) c_bc++;
    if (c_done) begin
      if (q_c.size() == 0) fail_now("c_unexpected_done");
      else begin
        ec = q_c.pop_front();
        compare("c", ec, c_conv, c_epochs, c_w1, c_w2, c_bias, cyc - c_t0 + 1, c_bc);
      end
    end
  end

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return a_done;
      1:       return x_done;
      default: return c_done;
    endcase
  endfunction

  task automatic pulse_start(input int sel, input logic [3:0] tg);
    @(negedge clk);
    case (sel)
      0:       begin a_start = 1'b1; a_target = tg; end
      1:       begin x_start = 1'b1; x_target = tg; end
      default: begin c_start = 1'b1; c_target = tg; end
    endcase
    @(negedge clk);
    a_start = 1'b0;
    x_start = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_of(sel)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now({tag, "_done_timeout"});
  endtask

  // Drive every {e1,e2} on instance a and compare s to the truth table.
  task automatic check_table(input logic [3:0] tg, input string tag);
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      a_e1 = v[1];
      a_e2 = v[0];
      #1;
      check($sformatf("%s_s_%0d", tag, i), a_s, int'(tg[v]));
    end
    a_e1 = 1'b0;
    a_e2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 0; a_target = '0; a_e1 = 0; a_e2 = 0;
    x_start = 0; x_target = '0; x_e1 = 0; x_e2 = 0;
    c_start = 0; c_target = '0; c_e1 = 0; c_e2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_s", a_s, 0);
    check("rst_w1", a_w1, 0);
    check("rst_w2", a_w2, 0);
    check("rst_bias", a_bias, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_converged", a_conv, 0);
    check("rst_epochs", a_epochs, 0);

    // 1. OR
    q_a.push_back(mk(1, 4, 1, 1, 0, 1'b1, 17, 16));
    pulse_start(0, 4'b1110);
    wait_done(0, 40, "or");
    check_table(4'b1110, "or");

    // 2. XOR never converges; gives up after 8 epochs
    q_x.push_back(mk(0, 8, 0, 0, 0, 1'b0, 33, 32));
    pulse_start(1, 4'b0110);
    wait_done(1, 60, "xor");

    // 3. AND then NAND on the same instance
    q_a.push_back(mk(1, 6, 2, 1, -2, 1'b1, 25, 24));
    pulse_start(0, 4'b1000);
    wait_done(0, 50, "and");
    check_table(4'b1000, "and");
    q_a.push_back(mk(1, 6, -2, -1, 3, 1'b1, 25, 24));
    pulse_start(0, 4'b0111);
    wait_done(0, 50, "nand");
    check_table(4'b0111, "nand");

    // 4. Clamping with 2-bit weights: bias would reach +2 in epoch 2
    q_c.push_back(mk(0, 16, -1, -1, 0, 1'b1, 65, 64));
    pulse_start(2, 4'b0111);
    repeat (6) @(negedge clk);
    check("sat_mid_w1", c_w1, -1);
    check("sat_mid_w2", c_w2, 0);
    check("sat_mid_bias", c_bias, 1);
    wait_done(2, 80, "sat");

    // 5. Reset during the 6th training cycle
    pulse_start(0, 4'b1000);
    repeat (5) @(negedge clk);
    check("abort_pre_busy", a_busy, 1);
    check("abort_pre_w1", a_w1, 1);
    check("abort_pre_epochs", a_epochs, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_w1", a_w1, 0);
    check("abort_w2", a_w2, 0);
    check("abort_bias", a_bias, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_converged", a_conv, 0);
    check("abort_epochs", a_epochs, 0);
    check("abort_s", a_s, 0);
    // start together with rst: rst wins
    @(negedge clk);
    rst = 1'b1;
    a_start = 1'b1;
    a_target = 4'b1110;
    @(negedge clk);
    rst = 1'b0;
    a_start = 1'b0;
    check("rst_and_start_busy", a_busy, 0);
    repeat (3) @(negedge clk);
    check("rst_and_start_idle", a_busy, 0);
    // fresh training after abort
    q_a.push_back(mk(1, 4, 1, 1, 0, 1'b1, 17, 16));
    pulse_start(0, 4'b1110);
    wait_done(0, 40, "post_abort_or");
    check_table(4'b1110, "post_abort_or");

    // 6. Extra start and target changes while busy are ignored
    q_a.push_back(mk(1, 4, 1, 1, 0, 1'b1, 17, 16));
    pulse_start(0, 4'b1110);
    repeat (3) @(negedge clk);
    a_start = 1'b1;
    a_target = 4'b0110;
    @(negedge clk);
    a_start = 1'b0;
    a_target = 4'b0001;
    repeat (4) @(negedge clk);
    a_target = 4'b1001;
    wait_done(0, 40, "busy_start");
    check_table(4'b1110, "busy_start");

    repeat (10) @(negedge clk);
    check("q_a_drained", q_a.size(), 0);
    check("q_x_drained", q_x.size(), 0);
    check("q_c_drained", q_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
